// File: rtl/perf_counter_bank_pkg.sv
// Shared types for the performance counter bank: event numbering used by
// getperf decode and the index-width helper.
package perf_counter_bank_pkg;

  typedef enum logic [2:0] {
    evt_cycle       = 3'd0,
    evt_instret     = 3'd1,
    evt_br_taken    = 3'd2,
    evt_br_mispred  = 3'd3,
    evt_icache_miss = 3'd4,
    evt_dcache_miss = 3'd5,
    evt_stall       = 3'd6,
    evt_mem_wait    = 3'd7
  } perf_evt_t;

  localparam int PERF_NUM_EVT = 8;

  // A single-counter bank still needs a one-bit index.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/perf_counter_bank_counter.sv
// One performance counter with a sticky overflow flag; a clear wins over
// an increment in the same cycle.
module perf_counter #(
  parameter int CTR_WIDTH = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CTR_WIDTH-1:0] count,
  output logic                 ovf
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  logic [CTR_WIDTH-1:0] count_r;
  logic                 ovf_r;

  // Counter and flag update; in saturate mode the flag marks reaching all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else if (clr) begin
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else if (inc) begin
      if (count_r == CTR_MAX) begin
        count_r <= SATURATE ? CTR_MAX : '0;
        ovf_r   <= 1'b1;
      end else begin
        count_r <= count_r + CTR_WIDTH'(1);
        ovf_r   <= ovf_r | (SATURATE & (count_r == (CTR_MAX - CTR_WIDTH'(1))));
      end
    end else begin
      count_r <= count_r;
      ovf_r   <= ovf_r;
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters read through a valid/ready request with a single
// registered response slot; supports clear, read-and-clear and freeze.
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int  NUM_CTR   = 8,
  parameter int  CTR_WIDTH = 32,
  parameter bit  SATURATE  = 1'b0,
  localparam int IDX_W     = idx_width(NUM_CTR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CTR-1:0]   event_i,
  input  logic                 freeze_i,
  input  logic                 clr_valid_i,
  input  logic                 clr_all_i,
  input  logic [IDX_W-1:0]     clr_idx_i,
  input  logic                 rd_valid_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  input  logic                 rd_clr_i,
  output logic                 rd_ready_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [CTR_WIDTH-1:0] resp_data_o,
  output logic                 resp_ovf_o,
  output logic                 resp_err_o,
  output logic [NUM_CTR-1:0]   ovf_o
);

  localparam logic [IDX_W:0] NUM_CTR_W = (IDX_W + 1)'(NUM_CTR);

  logic [CTR_WIDTH-1:0] count_s [NUM_CTR];
  logic [NUM_CTR-1:0]   ovf_s;
  logic [NUM_CTR-1:0]   inc_s;
  logic [NUM_CTR-1:0]   clr_s;
  logic                 rd_fire_s;
  logic                 rd_in_range_s;
  logic                 rd_clr_fire_s;
  logic [CTR_WIDTH-1:0] sel_data_s;
  logic                 sel_ovf_s;

  logic                 resp_valid_r;
  logic [CTR_WIDTH-1:0] resp_data_r;
  logic                 resp_ovf_r;
  logic                 resp_err_r;

  assign rd_ready_o    = ~resp_valid_r | resp_ready_i;
  assign rd_fire_s     = rd_valid_i & rd_ready_o;
  assign rd_in_range_s = ({1'b0, rd_idx_i} < NUM_CTR_W);
  assign rd_clr_fire_s = rd_fire_s & rd_clr_i & rd_in_range_s;
  assign inc_s         = event_i & {NUM_CTR{~freeze_i}};

  // Out-of-range indices match no counter, so neither clear nor readout sees them.
  for (genvar g = 0; g < NUM_CTR; g++) begin : g_ctr
    assign clr_s[g] = (clr_valid_i & (clr_all_i | (clr_idx_i == IDX_W'(g))))
                    | (rd_clr_fire_s & (rd_idx_i == IDX_W'(g)));

    perf_counter #(
      .CTR_WIDTH (CTR_WIDTH),
      .SATURATE  (SATURATE)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_s[g]),
      .clr   (clr_s[g]),
      .count (count_s[g]),
      .ovf   (ovf_s[g])
    );
  end

  // Read mux as an AND-OR tree over the pre-edge counter values.
  always_comb begin
    sel_data_s = '0;
    sel_ovf_s  = 1'b0;
    for (int i = 0; i < NUM_CTR; i++) begin
      sel_data_s = sel_data_s | (count_s[i] & {CTR_WIDTH{rd_idx_i == IDX_W'(i)}});
      sel_ovf_s  = sel_ovf_s | (ovf_s[i] & (rd_idx_i == IDX_W'(i)));
    end
  end

  // Response slot: load on accept, drop on consume, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
      resp_ovf_r   <= 1'b0;
      resp_err_r   <= 1'b0;
    end else if (rd_fire_s) begin
      resp_valid_r <= 1'b1;
      resp_data_r  <= rd_in_range_s ? sel_data_s : '0;
      resp_ovf_r   <= rd_in_range_s & sel_ovf_s;
      resp_err_r   <= ~rd_in_range_s;
    end else if (resp_ready_i) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
    end
  end

  assign resp_valid_o = resp_valid_r;
  assign resp_data_o  = resp_data_r;
  assign resp_ovf_o   = resp_ovf_r;
  assign resp_err_o   = resp_err_r;
  assign ovf_o        = ovf_s;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomised and directed bench for perf_counter_bank: a wrapping and a
// saturating instance share stimulus and are checked against a reference model.
module tb_perf_counter_bank;
  import perf_counter_bank_pkg::*;

  localparam int N   = 6;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   event_i;
  logic           freeze_i, clr_valid_i, clr_all_i;
  logic [2:0]     clr_idx_i, rd_idx_i;
  logic           rd_valid_i, rd_clr_i, resp_ready_i;

  logic [1:0]        rd_ready_o, resp_valid_o, resp_ovf_o, resp_err_o;
  logic [1:0][W-1:0] resp_data_o;
  logic [1:0][N-1:0] ovf_o;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 wraps, index 1 saturates
  int cnt_m [2][N];
  bit ovf_m [2][N];
  bit exp_valid;
  int exp_data [2];
  bit exp_rovf [2];
  bit exp_err;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    perf_counter_bank #(.NUM_CTR(N), .CTR_WIDTH(W), .SATURATE(1'(k))) dut (
      .clk          (clk),
      .rst          (rst),
      .event_i      (event_i),
      .freeze_i     (freeze_i),
      .clr_valid_i  (clr_valid_i),
      .clr_all_i    (clr_all_i),
      .clr_idx_i    (clr_idx_i),
      .rd_valid_i   (rd_valid_i),
      .rd_idx_i     (rd_idx_i),
      .rd_clr_i     (rd_clr_i),
      .rd_ready_o   (rd_ready_o[k]),
      .resp_valid_o (resp_valid_o[k]),
      .resp_ready_i (resp_ready_i),
      .resp_data_o  (resp_data_o[k]),
      .resp_ovf_o   (resp_ovf_o[k]),
      .resp_err_o   (resp_err_o[k]),
      .ovf_o        (ovf_o[k])
    );
  end

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        cnt_m[k][i] = 0;
        ovf_m[k][i] = 1'b0;
      end
      exp_data[k] = 0;
      exp_rovf[k] = 1'b0;
    end
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  function automatic int exp_ovf_vec(input int k);
    int v = 0;
    for (int i = 0; i < N; i++) if (ovf_m[k][i]) v |= (1 << i);
    return v;
  endfunction

  // One clock edge: advance the model from the inputs seen at that edge
  task automatic step();
    bit rdy, fire, inr, clr;
    @(posedge clk);
    rdy  = !exp_valid || resp_ready_i;
    fire = rd_valid_i && rdy;
    inr  = rd_idx_i < N;
    if (fire) begin
      for (int k = 0; k < 2; k++) begin
        exp_data[k] = inr ? cnt_m[k][rd_idx_i] : 0;
        exp_rovf[k] = inr ? ovf_m[k][rd_idx_i] : 1'b0;
      end
      exp_err   = !inr;
      exp_valid = 1'b1;
    end else if (resp_ready_i) begin
      exp_valid = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        clr = (clr_valid_i && (clr_all_i || clr_idx_i == i)) ||
              (fire && rd_clr_i && inr && rd_idx_i == i);
        if (clr) begin
          cnt_m[k][i] = 0;
          ovf_m[k][i] = 1'b0;
        end else if (event_i[i] && !freeze_i) begin
          if (k == 0) begin
            cnt_m[k][i] = (cnt_m[k][i] + 1) % (MAX + 1);
            if (cnt_m[k][i] == 0) ovf_m[k][i] = 1'b1;
          end else begin
            if (cnt_m[k][i] < MAX) cnt_m[k][i]++;
            if (cnt_m[k][i] == MAX) ovf_m[k][i] = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_read(input int idx, input bit clr);
    rd_valid_i   = 1'b1;
    rd_idx_i     = 3'(idx);
    rd_clr_i     = clr;
    resp_ready_i = 1'b1;
    step();
    rd_valid_i = 1'b0;
    rd_clr_i   = 1'b0;
  endtask

  task automatic clear_all();
    clr_valid_i = 1'b1;
    clr_all_i   = 1'b1;
    step();
    clr_valid_i = 1'b0;
    clr_all_i   = 1'b0;
  endtask

  // Continuous comparison against the model, on the inactive edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("resp_valid", k, resp_valid_o[k], exp_valid);
      chk("rd_ready", k, rd_ready_o[k], !exp_valid || resp_ready_i);
      chk("ovf_o", k, ovf_o[k], exp_ovf_vec(k));
      if (exp_valid) begin
        chk("resp_data", k, resp_data_o[k], exp_data[k]);
        chk("resp_ovf", k, resp_ovf_o[k], exp_rovf[k]);
        chk("resp_err", k, resp_err_o[k], exp_err);
      end
    end
  end

  initial begin
    event_i = '0; freeze_i = 1'b0; clr_valid_i = 1'b0; clr_all_i = 1'b0;
    clr_idx_i = '0; rd_valid_i = 1'b0; rd_idx_i = '0; rd_clr_i = 1'b0;
    resp_ready_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", k, resp_valid_o[k], 0);
      chk("reset_ready", k, rd_ready_o[k], 1);
      chk("reset_data", k, resp_data_o[k], 0);
      chk("reset_ovf", k, ovf_o[k], 0);
    end

    // Counting on 0 with a response pending, then asynchronous reset mid-cycle
    event_i = 6'b000001;
    repeat (4) step();
    rd_valid_i = 1'b1; rd_idx_i = 3'd0; resp_ready_i = 1'b0;
    step();
    rd_valid_i = 1'b0; event_i = '0;
    chk("pre_reset_data", 0, resp_data_o[0], 4);
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_valid", 0, resp_valid_o[0], 0);
    chk("async_rst_data", 0, resp_data_o[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    resp_ready_i = 1'b1;
    do_read(0, 1'b0);
    chk("post_reset_read", 0, resp_data_o[0], 0);

    // Wrap vs saturate on counter 3
    event_i = 6'b001000;
    repeat (256) step();
    event_i = '0;
    do_read(3, 1'b0);
    chk("wrap256_data", 0, resp_data_o[0], 0);
    chk("wrap256_ovf", 0, resp_ovf_o[0], 1);
    chk("wrap256_flag", 0, ovf_o[0][3], 1);
    chk("sat256_data", 1, resp_data_o[1], 255);
    chk("sat256_flag", 1, ovf_o[1][3], 1);
    event_i = 6'b001000;
    repeat (44) step();
    event_i = '0;
    do_read(3, 1'b0);
    chk("wrap300_data", 0, resp_data_o[0], 44);
    chk("sat300_data", 1, resp_data_o[1], 255);
    chk("sat300_ovf", 1, resp_ovf_o[1], 1);

    // Backpressure: response holds while events continue
    clear_all();
    event_i = 6'b000010;
    repeat (10) step();
    rd_valid_i = 1'b1; rd_idx_i = 3'd1; resp_ready_i = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_data", 0, resp_data_o[0], 10);
      chk("bp_not_ready", 0, rd_ready_o[0], 0);
      step();
    end
    rd_valid_i = 1'b0; resp_ready_i = 1'b1; event_i = '0;
    step();
    chk("bp_drained", 0, resp_valid_o[0], 0);
    chk("bp_ready", 0, rd_ready_o[0], 1);

    // Read-and-clear with a same-cycle event
    clear_all();
    event_i = 6'b000100;
    repeat (7) step();
    do_read(int'(evt_br_taken), 1'b1);
    event_i = '0;
    chk("rdclr_value", 0, resp_data_o[0], 7);
    do_read(2, 1'b0);
    chk("rdclr_after", 0, resp_data_o[0], 0);

    // Freeze blocks increments; clear-all beats events
    event_i = '1;
    repeat (3) step();
    freeze_i = 1'b1;
    repeat (4) step();
    freeze_i = 1'b0; event_i = '0;
    do_read(0, 1'b0);
    chk("freeze_hold", 0, resp_data_o[0], 3);
    event_i = '1;
    clear_all();
    event_i = '0;
    for (int i = 0; i < N; i++) begin
      do_read(i, 1'b0);
      chk("clrall_data", 1, resp_data_o[1], 0);
    end
    chk("clrall_ovf", 0, ovf_o[0], 0);

    // Out-of-range read and clear
    event_i = '1;
    repeat (2) step();
    event_i = '0;
    do_read(7, 1'b0);
    chk("oor_err", 0, resp_err_o[0], 1);
    chk("oor_data", 0, resp_data_o[0], 0);
    clr_valid_i = 1'b1; clr_idx_i = 3'd7;
    step();
    clr_idx_i = 3'd4;
    step();
    clr_valid_i = 1'b0;
    do_read(5, 1'b0);
    chk("oor_clr_ignored", 0, resp_data_o[0], 2);
    do_read(4, 1'b0);
    chk("idx_clr", 0, resp_data_o[0], 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      event_i      = N'($urandom);
      freeze_i     = ($urandom_range(0, 7) == 0);
      clr_valid_i  = ($urandom_range(0, 15) == 0);
      clr_all_i    = ($urandom_range(0, 3) == 0);
      clr_idx_i    = 3'($urandom_range(0, 7));
      rd_valid_i   = $urandom_range(0, 1);
      rd_idx_i     = 3'($urandom_range(0, 7));
      rd_clr_i     = ($urandom_range(0, 7) == 0);
      resp_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    rd_valid_i = 1'b0; clr_valid_i = 1'b0; event_i = '0; resp_ready_i = 1'b1;
    step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of NUM_CTR hardware performance counters serving the op_getperf instruction path. Counts per-cycle event strobes from the datapath and caches, supports per-counter clear, global freeze, optional saturation and sticky overflow flags. Readout uses a valid/ready request with a registered one-cycle response, consumed by the execute/writeback stage when op_getperf retires.

Parameters:
NUM_CTR, 8, number of counters (1..32)
CTR_WIDTH, 32, counter width in bits (8..64)
SATURATE, 0, 0 = wrap at 2^CTR_WIDTH, 1 = hold at all-ones
IDX_W, $clog2(NUM_CTR) with minimum 1, index width (derived localparam, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
event_i  in  NUM_CTR  bit i = one event for counter i this cycle
freeze_i  in  1  when 1, no counter increments
clr_valid_i  in  1  clear request this cycle
clr_all_i  in  1  with clr_valid_i: clear every counter and overflow flag
clr_idx_i  in  IDX_W  counter to clear when clr_all_i=0
rd_valid_i  in  1  read request
rd_idx_i  in  IDX_W  counter to read
rd_clr_i  in  1  read-and-clear
rd_ready_o  out  1  request accepted when rd_valid_i & rd_ready_o
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed when resp_valid_o & resp_ready_i
resp_data_o  out  CTR_WIDTH  counter value
resp_ovf_o  out  1  overflow flag of counter read
resp_err_o  out  1  rd_idx_i >= NUM_CTR
ovf_o  out  NUM_CTR  sticky overflow flags

Behaviour:
- Reset (asynchronous, any time, including mid-response): all counters 0, ovf_o 0, resp_valid_o 0, resp_data_o 0, resp_ovf_o 0, resp_err_o 0. rd_ready_o = 1 after reset.
- Increment: counter i += 1 on edge when event_i[i] & ~freeze_i, unless cleared that cycle.
- Wrap (SATURATE=0): all-ones + 1 -> 0, sets ovf_o[i]. Saturate (SATURATE=1): at all-ones stays, ovf_o[i] set on the increment that reaches all-ones and stays set.
- Clear: clr_valid_i with clr_all_i=1 zeroes all counters and ovf_o. With clr_all_i=0, zeroes counter clr_idx_i and its flag; out-of-range clr_idx_i ignored. Clear beats a same-cycle increment (event lost).
- rd_ready_o = ~resp_valid_o | resp_ready_i (combinational; single response slot).
- Accept: response registered on the edge; resp_valid_o high next cycle (latency 1). resp_data_o/resp_ovf_o = values BEFORE that edge's increment/clear. Held stable while resp_valid_o & ~resp_ready_i.
- Back-to-back: accept in same cycle response is consumed -> resp_valid_o stays 1 with new data.
- rd_clr_i on accepted read: counter and flag cleared on the same edge (increment that cycle lost), as a clear.
- Out-of-range rd_idx_i: resp_data_o 0, resp_ovf_o 0, resp_err_o 1, no state change; otherwise resp_err_o 0.
- Read and clr of same index same cycle: response returns pre-clear value.
- freeze_i gates increments only; clears and reads still act.

Decomposition:
- rv32i_types gains: perf_evt_t enum (evt_cycle=0, evt_instret, evt_br_taken, evt_br_mispred, evt_icache_miss, evt_dcache_miss, evt_stall, evt_mem_wait) and PERF_NUM_EVT=8 constant; getperf decode uses perf_evt_t as rd_idx_i.
- Sub-module perf_counter: one counter plus overflow flag with inc/clr inputs and SATURATE parameter, instantiated NUM_CTR times via generate.

Test Plan:
- Reset mid-count: event_i[0]=1 for 5 cycles, assert rst asynchronously -> counter 0, resp_valid_o 0 immediately; read idx 0 after release -> resp_data_o 0.
- Wrap: CTR_WIDTH=8, SATURATE=0, 256 events on counter 3 -> read gives 0, resp_ovf_o 1, ovf_o[3] 1; SATURATE=1, 300 events -> 255, ovf_o[3] 1.
- Latency/backpressure: counter 1 = 10, read with resp_ready_i=0 for 3 cycles while events continue -> resp_data_o holds 10, rd_ready_o 0; release -> one response, then rd_ready_o 1.
- Read-and-clear with event same cycle: counter 2 = 7, event_i[2]=1, rd_clr_i=1 -> response 7, counter reads 0 next.
- Clear priority/freeze: freeze_i=1, events for 4 cycles -> no change; clr_all with events -> all counters 0, ovf_o 0.
- Error: NUM_CTR=6, rd_idx_i=7 -> resp_err_o 1, resp_data_o 0; clr_idx_i=7 -> no counter changes.
